// File: rtl/ifu_fetch_pkg.sv
// ============================================================================
// Module      : ifu_fetch_pkg
// Description : Shared constants for the instruction fetch unit: widths,
//               reset PC, NOP encoding, instruction field ranges, FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ifu_fetch_pkg;

    localparam int          c_XLEN     = 64;
    localparam logic [63:0] c_RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] c_NOP      = 32'h0000_0013;

    localparam int c_OPCODE_LSB = 0;
    localparam int c_OPCODE_LEN = 7;
    localparam int c_FUNC3_LSB  = 12;
    localparam int c_FUNC3_LEN  = 3;
    localparam int c_FUNC7_LSB  = 25;
    localparam int c_FUNC7_LEN  = 7;

    localparam logic [2:0] c_ST_BOOT = 3'd0;
    localparam logic [2:0] c_ST_REQ  = 3'd1;
    localparam logic [2:0] c_ST_WAIT = 3'd2;
    localparam logic [2:0] c_ST_HOLD = 3'd3;
    localparam logic [2:0] c_ST_ERR  = 3'd4;

endpackage

`default_nettype wire

// File: rtl/ifu_pc_reg.sv
// ============================================================================
// Module      : ifu_pc_reg
// Description : Fetch PC register; loads a word-aligned redirect target or
//               advances by 4 (modulo 2^XLEN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_pc_reg
    import ifu_fetch_pkg::*;
#(
    parameter int              XLEN     = c_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(c_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic [XLEN-1:0] i_target,
    input  logic            i_advance,
    output logic [XLEN-1:0] o_pc
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_target_aligned;

    assign w_target_aligned = i_target & ~XLEN'(2'b11);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= w_target_aligned;
        end else if (i_advance) begin
            r_pc <= r_pc + XLEN'(4);
        end
    end

    assign o_pc = r_pc;

endmodule

`default_nettype wire

// File: rtl/ifu_fetch.sv
// ============================================================================
// Module      : ifu_fetch
// Description : Single-outstanding instruction fetch unit with redirect and
//               valid/ready decode handshake. Optional IFU_MISALIGN_CHK_EN
//               traps misaligned redirect targets in a sticky error state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int              XLEN     = c_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(c_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_o_ifu,
    output logic [XLEN-1:0] imem_addr_o_ifu,
    input  logic            imem_gnt_i_ifu,
    input  logic            imem_rvalid_i_ifu,
    input  logic [31:0]     imem_rdata_i_ifu,
    input  logic            jump_branch_i_ifu,
    input  logic [XLEN-1:0] jump_target_i_ifu,
    output logic            inst_valid_o_ifu,
    input  logic            inst_ready_i_ifu,
    output logic [31:0]     inst_o_ifu,
    output logic [XLEN-1:0] pc_o_ifu,
    output logic [6:0]      opcode_o_ifu,
    output logic [2:0]      func3_o_ifu,
    output logic [6:0]      func7_o_ifu,
    output logic            fetch_err_o_ifu
);

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic            r_drop;
    logic            w_drop_nxt;
    logic            r_inst_valid;
    logic            w_valid_nxt;
    logic [31:0]     r_inst;
    logic [XLEN-1:0] r_pc_out;
    logic            w_latch;
    logic            w_load;
    logic            w_advance;
    logic [XLEN-1:0] w_pc;

    ifu_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_target  (jump_target_i_ifu),
        .i_advance (w_advance),
        .o_pc      (w_pc)
    );

    // Redirect is evaluated first in every state so it overrides gnt/rvalid/ready.
    always_comb begin
        w_state_nxt = r_state;
        w_drop_nxt  = r_drop;
        w_valid_nxt = r_inst_valid;
        w_latch     = 1'b0;
        w_load      = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            c_ST_BOOT: w_state_nxt = c_ST_REQ;
            c_ST_REQ: begin
                if (jump_branch_i_ifu) begin
                    w_load = 1'b1;
                    if (imem_gnt_i_ifu) begin
                        w_drop_nxt  = 1'b1;
                        w_state_nxt = c_ST_WAIT;
                    end
                end else if (imem_gnt_i_ifu) begin
                    w_state_nxt = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                if (jump_branch_i_ifu) begin
                    w_load = 1'b1;
                    if (imem_rvalid_i_ifu) begin
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = c_ST_REQ;
                    end else begin
                        w_drop_nxt = 1'b1;
                    end
                end else if (imem_rvalid_i_ifu) begin
                    if (r_drop) begin
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = c_ST_REQ;
                    end else begin
                        w_latch     = 1'b1;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = c_ST_HOLD;
                    end
                end
            end
            c_ST_HOLD: begin
                if (jump_branch_i_ifu) begin
                    w_load      = 1'b1;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = c_ST_REQ;
                end else if (inst_ready_i_ifu) begin
                    w_advance   = 1'b1;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = c_ST_REQ;
                end
            end
`ifdef IFU_MISALIGN_CHK_EN
            c_ST_ERR: w_state_nxt = c_ST_ERR;
`endif
            default: w_state_nxt = c_ST_BOOT;
        endcase
`ifdef IFU_MISALIGN_CHK_EN
        if (w_load && (jump_target_i_ifu[1:0] != 2'b00)) begin
            w_load      = 1'b0;
            w_latch     = 1'b0;
            w_valid_nxt = 1'b0;
            w_drop_nxt  = 1'b0;
            w_state_nxt = c_ST_ERR;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= c_ST_BOOT;
            r_drop       <= 1'b0;
            r_inst_valid <= 1'b0;
            r_inst       <= c_NOP;
            r_pc_out     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_drop       <= w_drop_nxt;
            r_inst_valid <= w_valid_nxt;
            if (w_latch) begin
                r_inst   <= imem_rdata_i_ifu;
                r_pc_out <= w_pc;
            end
        end
    end

`ifdef IFU_MISALIGN_CHK_EN
    logic r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_state_nxt == c_ST_ERR) begin
            r_err <= 1'b1;
        end
    end

    assign fetch_err_o_ifu = r_err;
`else
    assign fetch_err_o_ifu = 1'b0;
`endif

    assign imem_req_o_ifu   = (r_state == c_ST_REQ);
    assign imem_addr_o_ifu  = w_pc;
    assign inst_valid_o_ifu = r_inst_valid;
    assign inst_o_ifu       = r_inst;
    assign pc_o_ifu         = r_pc_out;
    assign opcode_o_ifu     = r_inst[c_OPCODE_LSB +: c_OPCODE_LEN];
    assign func3_o_ifu      = r_inst[c_FUNC3_LSB  +: c_FUNC3_LEN];
    assign func7_o_ifu      = r_inst[c_FUNC7_LSB  +: c_FUNC7_LEN];

endmodule

`default_nettype wire

// File: tb/tb_ifu_fetch.sv
// ============================================================================
// Module      : tb_ifu_fetch
// Description : Self-checking bench for ifu_fetch: cycle vector table, corner
//               sequences and a randomized run against a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifu_fetch;
    import ifu_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic        jump = 1'b0;
    logic [63:0] target = '0;
    logic        ready = 1'b0;

    logic        req;
    logic [63:0] addr;
    logic        ivalid;
    logic [31:0] inst;
    logic [63:0] pco;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        ferr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ifu_fetch dut (
        .clk               (clk),
        .rst               (rst),
        .imem_req_o_ifu    (req),
        .imem_addr_o_ifu   (addr),
        .imem_gnt_i_ifu    (gnt),
        .imem_rvalid_i_ifu (rvalid),
        .imem_rdata_i_ifu  (rdata),
        .jump_branch_i_ifu (jump),
        .jump_target_i_ifu (target),
        .inst_valid_o_ifu  (ivalid),
        .inst_ready_i_ifu  (ready),
        .inst_o_ifu        (inst),
        .pc_o_ifu          (pco),
        .opcode_o_ifu      (opc),
        .func3_o_ifu       (f3),
        .func7_o_ifu       (f7),
        .fetch_err_o_ifu   (ferr)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        gnt = 1'b0; rvalid = 1'b0; rdata = '0; jump = 1'b0; target = '0; ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_req(input int max_cycles);
        int k = 0;
        while (!req && k < max_cycles) begin
            @(negedge clk);
            k++;
        end
        chk("req_timeout", {63'd0, req}, 64'd1);
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    typedef struct {
        logic        gnt, rvalid, ready, jump;
        logic [31:0] rdata;
        logic [63:0] target;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_valid;
        logic        chk_data;
        logic [31:0] e_inst;
        logic [63:0] e_pc;
        logic [6:0]  e_op;
        logic [2:0]  e_f3;
        logic [6:0]  e_f7;
    } vec_t;

    function automatic vec_t mk(input logic g, input logic rv, input logic [31:0] rd,
                                input logic rdy, input logic j, input logic [63:0] tg,
                                input logic er, input logic [63:0] ea, input logic ev,
                                input logic cd, input logic [31:0] ei, input logic [63:0] ep,
                                input logic [6:0] eo, input logic [2:0] e3, input logic [6:0] e7);
        vec_t v;
        v.gnt = g; v.rvalid = rv; v.rdata = rd; v.ready = rdy; v.jump = j; v.target = tg;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.chk_data = cd;
        v.e_inst = ei; v.e_pc = ep; v.e_op = eo; v.e_f3 = e3; v.e_f7 = e7;
        return v;
    endfunction

    vec_t vt[24];

    logic [63:0] exp_addr;
    logic [63:0] out_addr;
    logic [31:0] exp_word;
    bit          outst;
    bit          exp_vlow;
    int          hs;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //          gnt rv rdata          rdy jmp target            req addr              vld chk inst           pc                op     f3    f7
        vt[0]  = mk(0, 0, 32'h0,          0,  0,  64'h0,            0, 64'h0,             0,  1,  32'h0000_0013, 64'h0,             7'h13, 3'd0, 7'h00);
        vt[1]  = mk(1, 0, 32'h0,          0,  0,  64'h0,            1, 64'h8000_0000,     0,  0,  32'h0,         64'h0,             7'h00, 3'd0, 7'h00);
        vt[2]  = mk(0, 1, 32'h0000_0513,  0,  0,  64'h0,            0, 64'h0,             0,  0,  32'h0,         64'h0,             7'h00, 3'd0, 7'h00);
        for (int i = 3; i < 8; i++)
            vt[i] = mk(0, 0, 32'h0,       0,  0,  64'h0,            0, 64'h0,             1,  1,  32'h0000_0513, 64'h8000_0000,     7'h13, 3'd0, 7'h00);
        vt[8]  = mk(0, 0, 32'h0,          1,  0,  64'h0,            0, 64'h0,             1,  1,  32'h0000_0513, 64'h8000_0000,     7'h13, 3'd0, 7'h00);
        vt[9]  = mk(1, 0, 32'h0,          0,  0,  64'h0,            1, 64'h8000_0004,     0,  0,  32'h0,         64'h0,             7'h00, 3'd0, 7'h00);
        vt[10] = mk(0, 0, 32'h0,          0,  1,  64'h8000_1000,    0, 64'h0,             0,  0,  32'h0,         64'h0,             7'h00, 3'd0, 7'h00);
        vt[11] = mk(0, 1, 32'h0010_0093,  0,  0,  64'h0,            0, 64'h0,             0,  0,  32'h0,         64'h0,             7'h00, 3'd0, 7'h00);
        vt[12] = mk(1, 0, 32'h0,          0,  0,  64'h0,            1, 64'h8000_1000,     0,  0,  32'h0,         64'h0,             7'h00, 3'd0, 7'h00);
        vt[13] = mk(0, 1, 32'h4020_80B3,  0,  0,  64'h0,            0, 64'h0,             0,  0,  32'h0,         64'h0,             7'h00, 3'd0, 7'h00);
        vt[14] = mk(0, 0, 32'h0,          1,  1,  64'h8000_0200,    0, 64'h0,             1,  1,  32'h4020_80B3, 64'h8000_1000,     7'h33, 3'd0, 7'h20);
        vt[15] = mk(0, 0, 32'h0,          0,  1,  64'h8000_0400,    1, 64'h8000_0200,     0,  0,  32'h0,         64'h0,             7'h00, 3'd0, 7'h00);
        vt[16] = mk(1, 0, 32'h0,          0,  0,  64'h0,            1, 64'h8000_0400,     0,  0,  32'h0,         64'h0,             7'h00, 3'd0, 7'h00);
        vt[17] = mk(0, 1, 32'h0020_C0B3,  0,  1,  64'h8000_0800,    0, 64'h0,             0,  0,  32'h0,         64'h0,             7'h00, 3'd0, 7'h00);
        vt[18] = mk(1, 0, 32'h0,          0,  1,  64'h8000_0A00,    1, 64'h8000_0800,     0,  0,  32'h0,         64'h0,             7'h00, 3'd0, 7'h00);
        vt[19] = mk(0, 1, 32'h0010_0093,  0,  0,  64'h0,            0, 64'h0,             0,  0,  32'h0,         64'h0,             7'h00, 3'd0, 7'h00);
        vt[20] = mk(1, 0, 32'h0,          0,  0,  64'h0,            1, 64'h8000_0A00,     0,  0,  32'h0,         64'h0,             7'h00, 3'd0, 7'h00);
        vt[21] = mk(0, 1, 32'h0020_C0B3,  0,  0,  64'h0,            0, 64'h0,             0,  0,  32'h0,         64'h0,             7'h00, 3'd0, 7'h00);
        vt[22] = mk(0, 0, 32'h0,          1,  0,  64'h0,            0, 64'h0,             1,  1,  32'h0020_C0B3, 64'h8000_0A00,     7'h33, 3'd4, 7'h00);
        vt[23] = mk(0, 0, 32'h0,          0,  0,  64'h0,            1, 64'h8000_0A04,     0,  0,  32'h0,         64'h0,             7'h00, 3'd0, 7'h00);

        // Row i is checked at the i-th falling edge after reset release, then drives the next rising edge.
        do_reset();
        for (int i = 0; i < 24; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("vec%0d_req", i), {63'd0, req}, {63'd0, vt[i].e_req});
            if (vt[i].e_req) chk($sformatf("vec%0d_addr", i), addr, vt[i].e_addr);
            chk($sformatf("vec%0d_valid", i), {63'd0, ivalid}, {63'd0, vt[i].e_valid});
            chk($sformatf("vec%0d_err", i), {63'd0, ferr}, 64'd0);
            if (vt[i].chk_data) begin
                chk($sformatf("vec%0d_inst", i), {32'd0, inst}, {32'd0, vt[i].e_inst});
                chk($sformatf("vec%0d_pc", i), pco, vt[i].e_pc);
                chk($sformatf("vec%0d_opcode", i), {57'd0, opc}, {57'd0, vt[i].e_op});
                chk($sformatf("vec%0d_func3", i), {61'd0, f3}, {61'd0, vt[i].e_f3});
                chk($sformatf("vec%0d_func7", i), {57'd0, f7}, {57'd0, vt[i].e_f7});
            end
            gnt = vt[i].gnt; rvalid = vt[i].rvalid; rdata = vt[i].rdata;
            ready = vt[i].ready; jump = vt[i].jump; target = vt[i].target;
        end

        // PC wrap from the last word to address 0, then asynchronous mid-operation reset.
        do_reset();
        wait_req(8);
        jump = 1'b1; target = 64'hFFFF_FFFF_FFFF_FFFC;
        @(negedge clk);
        chk("wrap_redirect_addr", addr, 64'hFFFF_FFFF_FFFF_FFFC);
        jump = 1'b0; gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0000_0513;
        @(negedge clk);
        rvalid = 1'b0;
        chk("wrap_valid", {63'd0, ivalid}, 64'd1);
        chk("wrap_pc", pco, 64'hFFFF_FFFF_FFFF_FFFC);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk("wrap_next_addr", addr, 64'h0);
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0000_0013;
        @(negedge clk);
        rvalid = 1'b0;
        chk("wrap_zero_pc", pco, 64'h0);
        chk("wrap_zero_valid", {63'd0, ivalid}, 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_valid", {63'd0, ivalid}, 64'd0);
        chk("async_rst_req", {63'd0, req}, 64'd0);
        chk("async_rst_inst", {32'd0, inst}, {32'd0, c_NOP});
        chk("async_rst_pc", pco, 64'h0);
        chk("async_rst_addr", addr, 64'h8000_0000);

        // Misaligned redirect target.
        do_reset();
        wait_req(8);
        jump = 1'b1; target = 64'h8000_0002;
        @(negedge clk);
        jump = 1'b0;
`ifdef IFU_MISALIGN_CHK_EN
        for (int i = 0; i < 20; i++) begin
            chk("err_no_req", {63'd0, req}, 64'd0);
            chk("err_flag", {63'd0, ferr}, 64'd1);
            chk("err_no_valid", {63'd0, ivalid}, 64'd0);
            jump = (i == 5); target = 64'h8000_0100;
            gnt = 1'b1; ready = 1'b1;
            @(negedge clk);
        end
        idle_inputs();
        rst = 1'b0;
        #1;
        chk("err_cleared_by_reset", {63'd0, ferr}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        wait_req(8);
        chk("err_after_reset_addr", addr, 64'h8000_0000);
`else
        chk("misalign_masked_req", {63'd0, req}, 64'd1);
        chk("misalign_masked_addr", addr, 64'h8000_0000);
        chk("misalign_no_err", {63'd0, ferr}, 64'd0);
`endif

        // Randomized run against a transaction-level model of expected fetch addresses.
        do_reset();
        wait_req(8);
        exp_addr = 64'h8000_0000;
        outst = 1'b0;
        exp_vlow = 1'b0;
        hs = 0;
        out_addr = '0;
        for (int c = 0; c < 3000; c++) begin
            if (req) begin
                chk("rnd_addr", addr, exp_addr);
                chk("rnd_single_outstanding", {63'd0, outst}, 64'd0);
            end
            if (ivalid) begin
                exp_word = mem_word(exp_addr);
                chk("rnd_pc", pco, exp_addr);
                chk("rnd_inst", {32'd0, inst}, {32'd0, exp_word});
                chk("rnd_opcode", {57'd0, opc}, {57'd0, exp_word[6:0]});
                chk("rnd_func3", {61'd0, f3}, {61'd0, exp_word[14:12]});
                chk("rnd_func7", {57'd0, f7}, {57'd0, exp_word[31:25]});
            end
            if (exp_vlow) chk("rnd_valid_drop", {63'd0, ivalid}, 64'd0);
            chk("rnd_no_err", {63'd0, ferr}, 64'd0);

            gnt    = req && ($urandom_range(0, 2) != 0);
            rvalid = outst && ($urandom_range(0, 1) == 1);
            rdata  = rvalid ? mem_word(out_addr) : $urandom;
            ready  = ($urandom_range(0, 1) == 1);
            jump   = ($urandom_range(0, 11) == 0);
            target = {$urandom, $urandom};
`ifdef IFU_MISALIGN_CHK_EN
            target[1:0] = 2'b00;
`endif
            exp_vlow = ivalid && (jump || ready);
            if (req && gnt) begin
                outst    = 1'b1;
                out_addr = addr;
            end
            if (rvalid) outst = 1'b0;
            if (jump) begin
                exp_addr = target & ~64'h3;
            end else if (ivalid && ready) begin
                exp_addr = exp_addr + 64'd4;
                hs++;
            end
            @(negedge clk);
        end
        idle_inputs();
        chk("rnd_progress", {63'd0, hs >= 100}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit; it produces the instruction stream that the control decoder consumes.
- Holds the PC, issues one instruction-memory read at a time, and presents the fetched word to decode with a valid/ready handshake.
- Decode receives the word split into opcode/func3/func7 fields.
- Accepts a redirect (jump_branch plus target) from execute and discards any fetch already in flight.

Parameters:
- XLEN, 64, PC/address width.
- RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- imem_req_o_ifu  output  1  read request valid.
- imem_addr_o_ifu  output  XLEN  read address; word-aligned.
- imem_gnt_i_ifu  input  1  memory accepts the request this cycle.
- imem_rvalid_i_ifu  input  1  read data valid.
- imem_rdata_i_ifu  input  32  instruction word.
- jump_branch_i_ifu  input  1  redirect strobe from execute.
- jump_target_i_ifu  input  XLEN  redirect target.
- inst_valid_o_ifu  output  1  instruction available to decode.
- inst_ready_i_ifu  input  1  decode accepts.
- inst_o_ifu  output  32  full instruction.
- pc_o_ifu  output  XLEN  PC of inst_o_ifu.
- opcode_o_ifu  output  7  inst[6:0].
- func3_o_ifu  output  3  inst[14:12].
- func7_o_ifu  output  7  inst[31:25].
- fetch_err_o_ifu  output  1  misaligned-target error. Present only with IFU_MISALIGN_CHK_EN; otherwise tied 0.

Behaviour:
- Reset values:
  - state=BOOT, pc=RESET_PC.
  - imem_req_o_ifu=0, inst_valid_o_ifu=0, inst_o_ifu=32'h0000_0013 (nop), pc_o_ifu=0, drop=0, fetch_err_o_ifu=0.
- A reset asserted mid-operation aborts everything immediately. Any response arriving after reset deasserts is ignored while in BOOT.
- BOOT: one idle cycle after reset release, then go to REQ.
- REQ:
  - imem_req_o_ifu=1, imem_addr_o_ifu=pc, held stable until gnt.
  - On gnt, go to WAIT.
- WAIT:
  - Exactly one outstanding read.
  - On rvalid: latch rdata and pc into the output registers, raise inst_valid, go to HOLD.
  - The instruction is therefore visible the cycle after rvalid; minimum fetch-to-decode latency is 3 cycles from REQ entry with gnt and rvalid back-to-back.
- HOLD:
  - inst_valid=1; outputs stable until inst_ready.
  - On valid&ready: pc <= pc+4, inst_valid=0 next cycle, go to REQ.
  - Throughput is one instruction per 3 cycles at best; no prefetch.
- Field outputs are pure slices of the inst_o_ifu register, so they are valid only when inst_valid=1.
- Redirect (jump_branch_i_ifu=1) has priority over every other event in the same cycle:
  - REQ, no gnt: pc <= target, stay in REQ. The new address appears the next cycle. Dropping a request without gnt is legal.
  - REQ with gnt: set drop=1, pc <= target, go to WAIT.
  - WAIT: pc <= target, drop=1. If rvalid arrives in the same cycle, discard it and go to REQ.
  - WAIT with drop=1: the next rvalid is discarded (clear drop, go to REQ). No instruction is presented.
  - HOLD: inst_valid cleared next cycle, pc <= target, go to REQ. If ready was also high, the instruction counts as accepted and the target still wins over pc+4.
- PC arithmetic: modulo 2^XLEN, so wrap from all-ones to 0 is silent.
- Target bits [1:0] are forced to 0 before use.

Optional Feature:
- IFU_MISALIGN_CHK_EN defined:
  - A redirect with target[1:0]!=0 enters state ERR. No further requests are issued.
  - fetch_err_o_ifu=1 and sticky; inst_valid=0.
  - Only reset leaves ERR.
- Not defined: low bits are cleared silently, ERR state is absent, fetch_err_o_ifu=0.

Decomposition:
- Shared define file holds:
  - OpCodeLength/func3Length/func7Length field ranges.
  - XLEN, RESET_PC default, NOP constant 32'h0000_0013.
  - Encoded state constants BOOT/REQ/WAIT/HOLD/ERR.
- Optional sub-module ifu_pc_reg: holds pc, computes next-pc (target vs pc+4), applies target masking.

Test Plan:
- Reset release, memory returns 32'h00000513 one cycle after gnt -> first request addr 64'h80000000 on cycle 2. inst_valid with opcode 7'h13, func3 0, func7 0, pc_o 64'h80000000.
- Decode ready tied low for 5 cycles in HOLD -> inst_o/pc_o stable, no new request. Ready then high -> next request addr 64'h80000004.
- Redirect to 64'h80001000 in WAIT, stale rvalid with 32'h00100093 -> stale word never presented. Next request addr 64'h80001000.
- Redirect and valid&ready in the same cycle in HOLD, target 64'h80000200 -> next addr 64'h80000200, not pc+4.
- pc=64'hFFFFFFFF_FFFFFFFC accepted -> next request addr 0.
- IFU_MISALIGN_CHK_EN, redirect to 64'h80000002 -> fetch_err=1, no request for 20 cycles. Reset clears it. Without the macro -> request addr 64'h80000000.
